// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector: FSM state encodings
// and error-register bit positions.
package psum_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int ERR_PARTIAL_VAL = 0;  // i_psum_val neither all-0 nor all-1
    localparam int ERR_FIFO_DROP   = 1;  // pixel pushed into a full FIFO
    localparam int ERR_VAL_OUTSIDE = 2;  // psum valid seen outside ACC
    localparam int ERR_START_BUSY  = 3;  // start pulse while a job runs
    localparam int ERR_SAT         = 4;  // accumulator clamped
    localparam int ERR_USED_BITS   = 5;

endpackage

// File: rtl/psum_collector_fifo.sv
// psum_fifo: synchronous FIFO, parameterized width and power-of-2 depth.
// A push into a full FIFO is taken only when a pop happens in the same
// cycle. The head word comes straight from the storage array and reads
// as zero while the FIFO is empty.
module psum_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage write; contents are masked by empty_o so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/psum_collector.sv
// psum_collector: sums NUM_KERNEL lanes of signed PE partial sums over
// num_pass channel-group beats per pixel, buffers finished pixels in a
// small FIFO and tracks protocol errors in a sticky register.
// Optional feature: define PSUM_COLLECTOR_SAT_EN to saturate the
// accumulators instead of wrapping (clamps flag error bit 4).
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [7:0]                      i_cfg_num_pass,
    input  logic [15:0]                     i_cfg_num_pix,
    input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
    input  logic [NUM_KERNEL-1:0]           i_psum_val,
    output logic [ACC_WIDTH*NUM_KERNEL-1:0] o_data,
    output logic                            o_data_val,
    input  logic                            i_data_rdy,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [REG_WIDTH-1:0]            err_psum_val
);

    localparam int AW = ACC_WIDTH;

    state_e                  state_q, state_d;
    logic [7:0]              num_pass_q, num_pass_d, pass_q, pass_d;
    logic [15:0]             num_pix_q, num_pix_d, pix_q, pix_d;
    logic signed [AW-1:0]    acc_q [NUM_KERNEL];
    logic signed [AW-1:0]    acc_d [NUM_KERNEL];
    logic signed [BIT_WIDTH-1:0] lane_w [NUM_KERNEL];
    logic signed [AW:0]      sum_w  [NUM_KERNEL];
    logic [REG_WIDTH-1:0]    err_q, err_d;
    logic [AW*NUM_KERNEL-1:0] push_data;
    logic                    push_req, pop, fifo_full, fifo_empty;
    logic                    beat, partial, sat_hit, last_pass;

    function automatic logic ovf(input logic signed [AW:0] s);
        return s[AW] ^ s[AW-1];
    endfunction

    function automatic logic signed [AW-1:0] fit(input logic signed [AW:0] s);
`ifdef PSUM_COLLECTOR_SAT_EN
        if (ovf(s)) return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`endif
        return s[AW-1:0];
    endfunction

    assign o_data_val = !fifo_empty;
    assign pop        = o_data_val && i_data_rdy;
    assign o_busy     = (state_q != ST_IDLE);
    assign beat       = (state_q == ST_ACC) && (&i_psum_val);
    assign partial    = (|i_psum_val) && !(&i_psum_val);
    assign last_pass  = (pass_q == num_pass_q - 8'd1);
    assign err_psum_val = err_q;

    // Per-lane sum with one guard bit, used for both wrap and clamp.
    always_comb begin
        sat_hit = 1'b0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            lane_w[k] = i_psum[k*BIT_WIDTH +: BIT_WIDTH];
            sum_w[k]  = (AW+1)'(acc_q[k]) + (AW+1)'(lane_w[k]);
`ifdef PSUM_COLLECTOR_SAT_EN
            if (beat && ovf(sum_w[k])) sat_hit = 1'b1;
`endif
        end
    end

    // Next-state, datapath and error logic.
    always_comb begin
        state_d    = state_q;
        num_pass_d = num_pass_q;
        num_pix_d  = num_pix_q;
        pass_d     = pass_q;
        pix_d      = pix_q;
        acc_d      = acc_q;
        err_d      = err_q;
        push_req   = 1'b0;
        push_data  = '0;
        o_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_pass_d = (i_cfg_num_pass == 8'd0) ? 8'd1 : i_cfg_num_pass;
                    num_pix_d  = i_cfg_num_pix;
                    pass_d     = '0;
                    pix_d      = '0;
                    state_d    = (i_cfg_num_pix == 16'd0) ? ST_DRAIN : ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    for (int k = 0; k < NUM_KERNEL; k++) begin
                        if (last_pass) begin
                            push_data[k*AW +: AW] = fit(sum_w[k]);
                            acc_d[k] = '0;
                        end else begin
                            acc_d[k] = fit(sum_w[k]);
                        end
                    end
                    if (last_pass) begin
                        push_req = 1'b1;
                        pass_d   = '0;
                        pix_d    = pix_q + 16'd1;
                        if (pix_q == num_pix_q - 16'd1) state_d = ST_DRAIN;
                    end else begin
                        pass_d = pass_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    o_done  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (partial)                              err_d[ERR_PARTIAL_VAL] = 1'b1;
        if (push_req && fifo_full && !pop)        err_d[ERR_FIFO_DROP]   = 1'b1;
        if ((|i_psum_val) && state_q != ST_ACC)   err_d[ERR_VAL_OUTSIDE] = 1'b1;
        if (i_start && o_busy)                    err_d[ERR_START_BUSY]  = 1'b1;
        if (sat_hit)                              err_d[ERR_SAT]         = 1'b1;
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            num_pass_q <= 8'd1;
            num_pix_q  <= '0;
            pass_q     <= '0;
            pix_q      <= '0;
            err_q      <= '0;
            for (int k = 0; k < NUM_KERNEL; k++) acc_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            num_pass_q <= num_pass_d;
            num_pix_q  <= num_pix_d;
            pass_q     <= pass_d;
            pix_q      <= pix_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
        end
    end

    psum_fifo #(
        .WIDTH (AW*NUM_KERNEL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push_req),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (o_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector (BIT_WIDTH=8, NUM_KERNEL=4,
// ACC_WIDTH=8, FIFO_DEPTH=4). Expected values are hand-computed.
module tb_psum_collector;

    localparam int BW = 8;
    localparam int NK = 4;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [7:0]        i_cfg_num_pass;
    logic [15:0]       i_cfg_num_pix;
    logic [BW*NK-1:0]  i_psum;
    logic [NK-1:0]     i_psum_val;
    logic [AW*NK-1:0]  o_data;
    logic              o_data_val;
    logic              i_data_rdy;
    logic              o_busy;
    logic              o_done;
    logic [31:0]       err_psum_val;

    int total = 0;
    int bad   = 0;

    psum_collector #(
        .BIT_WIDTH (BW), .NUM_KERNEL (NK), .ACC_WIDTH (AW),
        .FIFO_DEPTH (4), .REG_WIDTH (32)
    ) dut (
        .clk (clk), .rst (rst), .i_start (i_start),
        .i_cfg_num_pass (i_cfg_num_pass), .i_cfg_num_pix (i_cfg_num_pix),
        .i_psum (i_psum), .i_psum_val (i_psum_val),
        .o_data (o_data), .o_data_val (o_data_val), .i_data_rdy (i_data_rdy),
        .o_busy (o_busy), .o_done (o_done), .err_psum_val (err_psum_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        return 32'(o_data[k*AW +: AW]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] np, input logic [15:0] nx);
        i_cfg_num_pass = np;
        i_cfg_num_pix  = nx;
        i_start        = 1'b1;
        step();
        i_start        = 1'b0;
    endtask

    task automatic beat(input logic [7:0] l0, input logic [7:0] l1);
        i_psum     = {16'd0, l1, l0};
        i_psum_val = 4'hF;
        step();
        i_psum_val = 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_val",  32'(o_data_val), 32'd0);
        chk("rst_busy", 32'(o_busy),     32'd0);
        chk("rst_done", 32'(o_done),     32'd0);
        chk("rst_err",  err_psum_val,    32'd0);
        chk("rst_data", o_data,          32'd0);
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        i_start = 0; i_cfg_num_pass = 0; i_cfg_num_pix = 0;
        i_psum = 0; i_psum_val = 0; i_data_rdy = 1;
        #2;
        do_reset();

        // Three-pass accumulation, two pixels, downstream always ready.
        start(8'd3, 16'd2);
        chk("t1_busy", 32'(o_busy), 32'd1);
        beat(8'd5, 8'd10);
        beat(-8'sd2, 8'd10);
        beat(8'd7, 8'd10);
        chk("t1_val0", 32'(o_data_val), 32'd1);
        chk("t1_p0l0", lane(0), 32'd10);
        chk("t1_p0l1", lane(1), 32'd30);
        beat(8'd1, 8'hFF);
        chk("t1_popd", 32'(o_data_val), 32'd0);
        beat(8'd1, 8'hFF);
        beat(8'd1, 8'hFF);
        chk("t1_val1", 32'(o_data_val), 32'd1);
        chk("t1_p1l0", lane(0), 32'd3);
        chk("t1_p1l1", lane(1), 32'hFD);
        chk("t1_nodn", 32'(o_done), 32'd0);
        step();
        chk("t1_done", 32'(o_done), 32'd1);
        step();
        chk("t1_dn0",  32'(o_done), 32'd0);
        chk("t1_idle", 32'(o_busy), 32'd0);
        chk("t1_err",  err_psum_val, 32'd0);

        // Overflow: six pixels into a depth-4 FIFO with no ready.
        i_data_rdy = 1'b0;
        start(8'd1, 16'd6);
        for (int i = 1; i <= 6; i++) beat(8'(i), 8'd0);
        chk("t2_err",  err_psum_val, 32'h2);
        chk("t2_busy", 32'(o_busy),  32'd1);
        i_data_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t2_pix%0d", i), lane(0), 32'(i));
            step();
        end
        chk("t2_empty", 32'(o_data_val), 32'd0);
        chk("t2_done",  32'(o_done),     32'd1);
        step();

        // Partial valid ignored; start while busy ignored; valid in IDLE.
        do_reset();
        start(8'd2, 16'd1);
        beat(8'd4, 8'd0);
        i_psum = {24'd0, 8'd50}; i_psum_val = 4'b0111;
        step();
        i_psum_val = 4'h0;
        chk("t3_err0", err_psum_val, 32'h1);
        i_cfg_num_pix = 16'd0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        beat(8'd6, 8'd0);
        chk("t3_val", 32'(o_data_val), 32'd1);
        chk("t3_pix", lane(0), 32'd10);
        chk("t3_err", err_psum_val, 32'h9);
        step();
        chk("t3_done", 32'(o_done), 32'd1);
        step();
        i_psum_val = 4'h1;
        step();
        i_psum_val = 4'h0;
        chk("t3_err2", err_psum_val, 32'hD);

        // 127 + 127 in an 8-bit accumulator.
        do_reset();
        start(8'd2, 16'd1);
        beat(8'd127, 8'd0);
        beat(8'd127, 8'd0);
        chk("t4_val", 32'(o_data_val), 32'd1);
`ifdef PSUM_COLLECTOR_SAT_EN
        chk("t4_pix", lane(0), 32'h7F);
        chk("t4_err", err_psum_val, 32'h10);
`else
        chk("t4_pix", lane(0), 32'hFE);
        chk("t4_err", err_psum_val, 32'h0);
`endif
        step();
        chk("t4_done", 32'(o_done), 32'd1);
        step();

        // Reset mid-job with two pixels buffered, then a clean job.
        do_reset();
        i_data_rdy = 1'b0;
        start(8'd1, 16'd4);
        beat(8'd1, 8'd0);
        beat(8'd2, 8'd0);
        chk("t5_buf", 32'(o_data_val), 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_val",  32'(o_data_val), 32'd0);
        chk("t5_busy", 32'(o_busy),     32'd0);
        chk("t5_dn",   32'(o_done),     32'd0);
        step();
        chk("t5_dn1",  32'(o_done),     32'd0);
        rst = 1'b1;
        step();
        chk("t5_dn2",  32'(o_done),     32'd0);
        i_data_rdy = 1'b1;
        start(8'd1, 16'd1);
        beat(8'd9, 8'd3);
        chk("t5_pix0", lane(0), 32'd9);
        chk("t5_pix1", lane(1), 32'd3);
        step();
        chk("t5_done", 32'(o_done), 32'd1);
        step();

        // Push into a full FIFO while a pop happens in the same cycle.
        i_data_rdy = 1'b0;
        start(8'd1, 16'd5);
        for (int i = 1; i <= 4; i++) beat(8'(i), 8'd0);
        chk("t6_head", lane(0), 32'd1);
        i_data_rdy = 1'b1;
        beat(8'd5, 8'd0);
        chk("t6_err", err_psum_val, 32'h0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("t6_pix%0d", i), lane(0), 32'(i));
            step();
        end
        chk("t6_done", 32'(o_done), 32'd1);
        step();
        chk("t6_idle", 32'(o_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, width of one incoming kernel psum (signed).
REQ-002 SHALL have parameter NUM_KERNEL, default 4, number of kernel lanes.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, width of each accumulator and output lane (signed).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2).
REQ-005 SHALL have parameter REG_WIDTH, default 32, width of the error register.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_start, input, 1, one-cycle start pulse; configuration sampled in the same cycle.
REQ-009 SHALL have port i_cfg_num_pass, input, 8, channel-group beats summed per output pixel; 0 treated as 1.
REQ-010 SHALL have port i_cfg_num_pix, input, 16, output pixels per job; 0 completes immediately.
REQ-011 SHALL have port i_psum, input, BIT_WIDTH*NUM_KERNEL, per-kernel psums; lane k at bits [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k].
REQ-012 SHALL have port i_psum_val, input, NUM_KERNEL, per-lane valid from the PE array.
REQ-013 SHALL have port o_data, output, ACC_WIDTH*NUM_KERNEL, head-of-FIFO pixel; same lane packing as i_psum.
REQ-014 SHALL have port o_data_val, output, 1, o_data is valid.
REQ-015 SHALL have port i_data_rdy, input, 1, downstream ready; a transfer occurs when o_data_val && i_data_rdy.
REQ-016 SHALL have port o_busy, output, 1, job in progress.
REQ-017 SHALL have port o_done, output, 1, one-cycle job-complete pulse.
REQ-018 SHALL have port err_psum_val, output, REG_WIDTH, sticky error flags.

Function
REQ-019 SHALL implement FSM IDLE -> ACC -> DRAIN -> IDLE.
REQ-020 SHALL leave IDLE for ACC on i_start, or for DRAIN when i_cfg_num_pix==0.
REQ-021 SHALL move from ACC to DRAIN when the last pixel is pushed.
REQ-022 SHALL move from DRAIN to IDLE when the FIFO is empty, pulsing o_done in that transition cycle.
REQ-023 SHALL treat a beat as all bits of i_psum_val high in state ACC.
REQ-024 SHALL, on a beat, add each sign-extended lane to its accumulator and increment the pass counter.
REQ-025 SHALL, on the beat where the pass counter equals num_pass-1, push {acc_k + psum_k} to the FIFO, clear the accumulators and pass counter, and increment the pixel counter.
REQ-026 SHALL wrap accumulation modulo 2^ACC_WIDTH unless PSUM_COLLECTOR_SAT_EN is defined.
REQ-027 SHALL assert o_data_val in cycle N+1 for a push in cycle N into an empty FIFO.
REQ-028 SHALL drive o_data from registered FIFO storage.
REQ-029 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle.
REQ-030 SHALL drop the pixel and set err bit 1 on any other push into a full FIFO; the pixel counter still increments.
REQ-031 SHALL set err bit 0 and ignore the beat when i_psum_val is partially set (neither all-0 nor all-1).
REQ-032 SHALL set err bit 2 when i_psum_val is nonzero outside ACC.
REQ-033 SHALL set err bit 3 on i_start while o_busy; that i_start SHALL be ignored.
REQ-034 SHALL keep err bits sticky until reset, with unused bits 0.
REQ-035 SHALL assert o_busy in ACC and DRAIN.

Reset
REQ-036 SHALL, on rst low, immediately put the FSM in IDLE; clear accumulators, counters and FIFO pointers; and drive o_data_val=0, o_done=0, o_busy=0, err_psum_val=0, o_data=0.
REQ-037 SHALL, when reset occurs mid-job, discard all buffered pixels and emit no o_done.

Configuration
REQ-038 SHALL, with PSUM_COLLECTOR_SAT_EN defined, clamp each accumulation and push result to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set err bit 4 on each clamp; without it, arithmetic wraps and bit 4 stays 0.

Structure
REQ-039 SHALL take the FSM state encodings and err bit indices from the shared accelerator package/header.
REQ-040 SHALL use one sub-module, psum_fifo, a synchronous FIFO with parameterized width and depth and full/empty outputs.

Verification
REQ-041 Bench SHALL cover: num_pass=3, num_pix=2, lane0 psums 5,-2,7 then 1,1,1, rdy=1 -> o_data lane0 10 then 3; o_done one cycle after the last pop.
REQ-042 Bench SHALL cover: rdy=0, FIFO_DEPTH=4, num_pass=1, num_pix=6 -> 4 pixels buffered, err bit 1 set, 2 pixels dropped, first 4 values intact.
REQ-043 Bench SHALL cover: i_psum_val=4'b0111 in ACC -> err bit 0 set, accumulators unchanged.
REQ-044 Bench SHALL cover: with SAT_EN, ACC_WIDTH=8, lane psum 127 twice, num_pass=2 -> output 127, err bit 4 set; without SAT_EN -> output -2.
REQ-045 Bench SHALL cover: rst low during ACC with 2 pixels buffered -> o_data_val=0 immediately, no o_done; a new job then runs correctly.
REQ-046 Bench SHALL cover: FIFO full with rdy=1 and a push in the same cycle -> no drop, err bit 1 clear.
